zacapa_uart_tx: RTL and testbench
=================================

# zacapa_uart_tx

Serial transmitter stage directly downstream of the chip's ASCII text sequencer. It accepts 8-bit ASCII characters through a valid/ready handshake and buffers them in a small FIFO. It emits each character on a single UART line as an 8N1 frame, with optional even parity, so the verses can be read on a terminal instead of only on the parallel output pins.

## Interface
Parameters:
- CLKS_PER_BIT, 434: clock cycles per UART bit (50 MHz / 115200); legal range 2..65535
- FIFO_DEPTH, 4: character buffer entries; power of two, at least 2

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_data  in  8  ASCII character from the sequencer
- in_valid  in  1  in_data holds a character to send
- in_ready  out  1  FIFO can accept; equals (not full) and (not reset)
- tx  out  1  UART line, registered, idles high
- busy  out  1  high while the FSM is not IDLE or the FIFO is non-empty

## Operation
- Push: a character is written on a rising edge with in_valid=1 and in_ready=1. in_data is ignored otherwise.
- A push while full is refused, even if a pop happens in the same cycle; the sender holds the character.
- A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: if the FIFO is non-empty, pop the head into an 8-bit shift register and go to START. Otherwise stay in IDLE with tx=1.
- Each of START, DATA, PARITY and STOP holds one bit for exactly CLKS_PER_BIT cycles, timed by a baud counter of $clog2(CLKS_PER_BIT) bits that counts from 0 to CLKS_PER_BIT-1.
- START drives tx=0.
- DATA sends bit 0 first. A 3-bit index counts 0..7, and the state exits after bit 7.
- PARITY drives the XOR of the 8 data bits (even parity).
- STOP drives tx=1.
- At the end of STOP: if the FIFO is non-empty, pop and go directly to START with no idle bit. Otherwise go to IDLE.
- All characters are sent verbatim, including 0x0A and bytes above 0x7F.

## Timing
- Reset values: tx=1, busy=0, in_ready=0 while reset is high; FSM in IDLE, FIFO empty, counters 0.
- After reset falls, in_ready=1 from the first cycle.
- Latency: handshake at edge N into an empty, idle block, then pop at edge N+1. tx goes low immediately after edge N+1.
- Frame length: 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
- Back-to-back characters have zero gap between a stop bit and the next start bit.
- Reset mid-frame: tx is forced high asynchronously, the frame is abandoned, and the FIFO is flushed. Partial frames are never resumed.
- in_ready is combinational from the FIFO count and reset. tx and busy are registered.

## Configuration
- ZACAPA_UART_PARITY_EN defined: the PARITY state is present and frames are 11 bits with even parity before the stop bit.
- ZACAPA_UART_PARITY_EN undefined: there is no PARITY state, DATA goes straight to STOP, and frames are 10 bits.

## Structure
- Package zacapa_uart_pkg holds:
  - the FSM state enum;
  - the idle line level constant (1'b1);
  - the data width constant (8).
- Sub-module zacapa_byte_fifo: a synchronous FIFO with the same clk/reset, push/pop, full/empty and a count of $clog2(FIFO_DEPTH)+1 bits. It uses circular pointers that wrap modulo FIFO_DEPTH.

## Test plan
- Reset idle: hold reset, then release → tx=1, busy=0, in_ready=0 during reset and 1 afterwards; no activity on tx for 100 cycles.
- Single frame, CLKS_PER_BIT=4, push 0x41 → tx low in cycles 2–5 after the handshake edge, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then stop high. busy falls 40 cycles after the pop.
- Backpressure and back-to-back, depth 4: push 0x50,0x50,0x72,0x6F,0x79,0x65 on consecutive cycles → first five accepted and in_ready=0 on the sixth. The sixth is accepted when the first stop bit ends. All six frames are contiguous, with no idle bit between them.
- Reset mid-frame during data bit 3 of 0x7A with 2 bytes queued → tx=1 at once and FIFO empty. A following push of 0x0A yields one clean frame only.
- Parity with ZACAPA_UART_PARITY_EN, push 0x61 → parity bit is 1 and the frame is 44 cycles at CLKS_PER_BIT=4. Without the macro, the stop bit follows bit 7 directly and the frame is 40 cycles.
- Wrap-around: stream 126 characters through continuously with random in_valid gaps → the decoded tx sequence matches the pushed sequence exactly, with no loss or duplication across pointer wrap.

Source files
------------

// File: rtl/zacapa_uart_pkg.sv
// ============================================================================
// zacapa_uart_pkg : shared types and constants for the zacapa UART transmitter
// Rev 1.0 -- initial release. Optional feature macro: ZACAPA_UART_PARITY_EN
// ============================================================================
`default_nettype none

package zacapa_uart_pkg;

   localparam int   DATA_W     = 8;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef ZACAPA_UART_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/zacapa_byte_fifo.sv
// ============================================================================
// zacapa_byte_fifo : small synchronous byte FIFO with circular pointers
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module zacapa_byte_fifo
   import zacapa_uart_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [DATA_W-1:0]        pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push_ok;
   logic              pop_ok;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;

   // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

`default_nettype wire

// File: rtl/zacapa_uart_tx.sv
// ============================================================================
// zacapa_uart_tx : buffered 8N1 UART transmitter, optional even parity
// Rev 1.0 -- initial release. Optional feature macro: ZACAPA_UART_PARITY_EN
// ============================================================================
`default_nettype none

module zacapa_uart_tx
   import zacapa_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx,
   output logic              busy
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   uart_state_e       state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              parity_d;
`ifdef ZACAPA_UART_PARITY_EN
   logic              parity_q;
`endif

   logic              push;
   logic              pop;
   logic [DATA_W-1:0] head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              baud_end;

   assign in_ready = !fifo_full && !reset;
   assign push     = in_valid && in_ready;
   assign baud_end = (baud_q == BAUD_LAST);
   assign tx       = tx_q;
   assign busy     = busy_q;

   zacapa_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (in_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      pop       = 1'b0;
`ifdef ZACAPA_UART_PARITY_EN
      parity_d  = parity_q;
`else
      parity_d  = 1'b0;
`endif

      if (state_q != ST_IDLE) begin
         baud_d = baud_end ? '0 : baud_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               shift_d   = head;
               parity_d  = ^head;
               baud_d    = '0;
               bit_idx_d = '0;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (baud_end) begin
               bit_idx_d = '0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (baud_end) begin
               if (bit_idx_q == 3'd7) begin
`ifdef ZACAPA_UART_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = shift_q >> 1;
               end
            end
         end
`ifdef ZACAPA_UART_PARITY_EN
         ST_PARITY: begin
            if (baud_end) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            // Chain straight into the next start bit when more data waits
            if (baud_end) begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  shift_d   = head;
                  parity_d  = ^head;
                  bit_idx_d = '0;
                  state_d   = ST_START;
               end else begin
                  state_d   = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            baud_d  = '0;
         end
      endcase

      // Line level is decoded from the next state so tx is a clean flop output
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
`ifdef ZACAPA_UART_PARITY_EN
         ST_PARITY: tx_d = parity_d;
`endif
         default:   tx_d = IDLE_LEVEL;
      endcase

      busy_d = (state_d != ST_IDLE) || push || (fifo_count > CNT_W'(pop));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= IDLE_LEVEL;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

`ifdef ZACAPA_UART_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) parity_q <= 1'b0;
      else       parity_q <= parity_d;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_zacapa_uart_tx.sv
// ============================================================================
// tb_zacapa_uart_tx : self-checking bench for zacapa_uart_tx (CLKS_PER_BIT=4)
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module tb_zacapa_uart_tx;

   localparam int C    = 4;
   localparam int D    = 4;
`ifdef ZACAPA_UART_PARITY_EN
   localparam int FB   = 11;
`else
   localparam int FB   = 10;
`endif
   localparam int FC   = FB * C;
   localparam int MAXC = 16384;
   localparam int NWRAP = 126;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       tx;
   logic       busy;

   int   cyc = 0;
   logic tx_log   [MAXC];
   logic busy_log [MAXC];

   int   n_cmp = 0;
   int   n_err = 0;

   byte unsigned dec_q[$];
   int           dec_start[$];
   int           dec_bad;

   zacapa_uart_tx #(
      .CLKS_PER_BIT (C),
      .FIFO_DEPTH   (D)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .tx       (tx),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Line recorder: value after edge number cyc
   always @(negedge clk) begin
      if (cyc < MAXC) begin
         tx_log[cyc]   = tx;
         busy_log[cyc] = busy;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Expected line level of frame bit k for byte b
   function automatic logic exp_bit(input logic [7:0] b, input int k);
      if (k == 0)               return 1'b0;
      if (k >= 1 && k <= 8)     return b[k-1];
      if (k == 9 && FB == 11)   return ^b;
      return 1'b1;
   endfunction

   // Handshake one byte; returns the edge number at which it was accepted
   task automatic push_one(input logic [7:0] b, output int hs_edge);
      int t;
      t        = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && t < 2000) begin
         tick();
         t++;
      end
      if (t >= 2000) chk("push_timeout", 32'd1, 32'd0);
      tick();
      hs_edge  = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int t;
      t = 0;
      while (busy && t < bound) begin
         tick();
         t++;
      end
      if (t >= bound) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   // Behavioural UART receiver over the recorded line, sampling mid-bit
   task automatic decode(input int from, input int to);
      int         i;
      logic [7:0] b;
      dec_q.delete();
      dec_start.delete();
      dec_bad = 0;
      i = from;
      while (i + FC <= to) begin
         if (tx_log[i] === 1'b0) begin
            for (int k = 0; k < 8; k++) b[k] = tx_log[i + (k + 1) * C + C / 2];
            if (tx_log[i + C / 2] !== 1'b0) dec_bad++;
`ifdef ZACAPA_UART_PARITY_EN
            if (tx_log[i + 9 * C + C / 2] !== ^b) dec_bad++;
`endif
            if (tx_log[i + (FB - 1) * C + C / 2] !== 1'b1) dec_bad++;
            dec_q.push_back(b);
            dec_start.push_back(i);
            i += FC;
         end else begin
            i++;
         end
      end
   endtask

   task automatic single_frame(input logic [7:0] b, input string tag);
      int         n;
      logic [C-1:0] v;
      push_one(b, n);
      repeat (FC + 6) tick();
      chk({tag, "_pre_idle"}, 32'(tx_log[n]), 32'd1);
      for (int k = 0; k < FB; k++) begin
         for (int j = 0; j < C; j++) v[j] = tx_log[n + 1 + k * C + j];
         chk($sformatf("%s_bit%0d", tag, k), 32'(v), 32'({C{exp_bit(b, k)}}));
      end
      chk({tag, "_post_idle"}, 32'(tx_log[n + 1 + FC]), 32'd1);
      chk({tag, "_busy_last"}, 32'(busy_log[n + FC]), 32'd1);
      chk({tag, "_busy_fall"}, 32'(busy_log[n + 1 + FC]), 32'd0);
   endtask

   initial begin
      logic [7:0] bp_bytes [6];
      logic [7:0] wrap_exp [NWRAP];
      int         n0, acc, t, r, idx, errs, dummy;
      logic       accept;

      bp_bytes = '{8'h50, 8'h50, 8'h72, 8'h6F, 8'h79, 8'h65};

      // Reset and idle line
      repeat (3) tick();
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      errs = 0;
      repeat (100) begin
         tick();
         if (tx !== 1'b1) errs++;
         if (busy !== 1'b0) errs++;
      end
      chk("idle_quiet", 32'(errs), 32'd0);

      // Single frames; 0x61 exercises the parity bit when enabled
      single_frame(8'h41, "f41");
      single_frame(8'h61, "f61");

      // Backpressure and back-to-back frames
      n0 = 0;
      for (int i = 0; i < 6; i++) begin
         in_data  = bp_bytes[i];
         in_valid = 1'b1;
         chk($sformatf("bp_ready%0d", i), 32'(in_ready), (i < 5) ? 32'd1 : 32'd0);
         if (i < 5) begin
            tick();
            if (i == 0) n0 = cyc;
         end
      end
      t = 0;
      while (!in_ready && t < 1000) begin
         tick();
         t++;
      end
      tick();
      acc      = cyc;
      in_valid = 1'b0;
      chk("bp_accept_edge", 32'(acc), 32'(n0 + FC + 2));
      wait_idle(6 * FC + 100);
      repeat (4) tick();
      decode(n0, cyc);
      chk("bp_frames", 32'(dec_q.size()), 32'd6);
      chk("bp_bad", 32'(dec_bad), 32'd0);
      for (int k = 0; k < 6 && k < dec_q.size(); k++) begin
         chk($sformatf("bp_byte%0d", k), 32'(dec_q[k]), 32'(bp_bytes[k]));
         chk($sformatf("bp_start%0d", k), 32'(dec_start[k]), 32'(n0 + 1 + k * FC));
      end

      // Reset during data bit 3 of 0x7A with two bytes queued
      push_one(8'h7A, n0);
      push_one(8'($urandom), dummy);
      push_one(8'($urandom), dummy);
      t = 0;
      while (cyc < n0 + 2 + 4 * C && t < 200) begin
         tick();
         t++;
      end
      reset = 1'b1;
      #1;
      chk("mid_rst_tx", 32'(tx), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd0);
      tick();
      reset = 1'b0;
      r = cyc + 1;
      tick();
      chk("post_mid_busy", 32'(busy), 32'd0);
      chk("post_mid_tx", 32'(tx), 32'd1);
      push_one(8'h0A, dummy);
      wait_idle(6 * FC);
      repeat (FC) tick();
      decode(r, cyc);
      chk("mid_frames", 32'(dec_q.size()), 32'd1);
      if (dec_q.size() > 0) chk("mid_byte", 32'(dec_q[0]), 32'h0A);

      // Continuous stream with random valid gaps across pointer wrap
      for (int k = 0; k < NWRAP; k++) wrap_exp[k] = 8'($urandom);
      r   = cyc;
      idx = 0;
      t   = 0;
      while (idx < NWRAP && t < 12000) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
         end else begin
            in_valid = 1'b1;
            in_data  = wrap_exp[idx];
         end
         accept = in_valid && in_ready;
         tick();
         if (accept) idx++;
         t++;
      end
      in_valid = 1'b0;
      chk("wrap_pushed", 32'(idx), 32'(NWRAP));
      wait_idle((D + 2) * FC);
      repeat (4) tick();
      decode(r, cyc);
      chk("wrap_frames", 32'(dec_q.size()), 32'(NWRAP));
      chk("wrap_bad", 32'(dec_bad), 32'd0);
      errs = 0;
      for (int k = 0; k < NWRAP && k < dec_q.size(); k++) begin
         if (dec_q[k] !== wrap_exp[k]) errs++;
      end
      chk("wrap_data", 32'(errs), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
